// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes SPI slave command words and shares one single-port RAM
// round-robin with a host port. Optional macro SPI_RD_ADDR_INC_EN auto-increments rd_addr per SPI read.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [7:0]           host_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_din,
    input  logic [7:0]           ram_dout,
    output logic                 spi_ovf
);
    typedef enum logic [1:0] {ARB, ACCESS, RETURN} state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;

    state_t               state, state_nxt;
    logic                 rx_valid_q;
    logic                 accept;
    logic [1:0]           opcode;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic                 spi_pend, spi_we;
    logic [ADDR_SIZE-1:0] spi_addr;
    logic [7:0]           spi_wdata;
    logic                 last_host;
    logic                 gnt_spi, acc_we;
    logic                 grant_spi, grant_host;
    logic                 spi_busy;

    assign opcode   = rx_data[9:8];
    assign payload  = rx_data[7:0];
    assign accept   = rx_valid & ~rx_valid_q;
    // gnt_spi/acc_we describe the access currently in ACCESS or RETURN
    assign spi_busy = spi_pend | ((state != ARB) & gnt_spi);

    always_comb begin
        state_nxt  = state;
        grant_spi  = 1'b0;
        grant_host = 1'b0;
        case (state)
            ARB: begin
                if (spi_pend && (!host_req || last_host)) grant_spi = 1'b1;
                else if (host_req)                        grant_host = 1'b1;
                if (grant_spi || grant_host) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = acc_we ? ARB : RETURN;
            RETURN:  state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= state_nxt;
    end

    // Command decode; SPI RAM requests latch their address at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            spi_pend   <= 1'b0;
            spi_we     <= 1'b0;
            spi_addr   <= '0;
            spi_wdata  <= '0;
            spi_ovf    <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (grant_spi) spi_pend <= 1'b0;
`ifdef SPI_RD_ADDR_INC_EN
            if (state == ACCESS && gnt_spi && !acc_we) rd_addr <= rd_addr + 1'b1;
`endif
            if (accept) begin
                case (opcode)
                    OP_WR_ADDR: wr_addr <= ADDR_SIZE'(payload);
                    OP_RD_ADDR: rd_addr <= ADDR_SIZE'(payload);
                    default: begin
                        if (spi_busy) begin
                            spi_ovf <= 1'b1;
                        end else begin
                            spi_pend  <= 1'b1;
                            spi_we    <= ~opcode[1];
                            spi_addr  <= opcode[1] ? rd_addr : wr_addr;
                            spi_wdata <= payload;
                        end
                    end
                endcase
            end
        end
    end

    // RAM port is registered at the grant, so it is live exactly during ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_host <= 1'b1;
            gnt_spi   <= 1'b0;
            acc_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            host_gnt  <= 1'b0;
        end else begin
            ram_en   <= grant_spi | grant_host;
            host_gnt <= grant_host;
            ram_we   <= 1'b0;
            if (grant_spi) begin
                last_host <= 1'b0;
                gnt_spi   <= 1'b1;
                acc_we    <= spi_we;
                ram_we    <= spi_we;
                ram_addr  <= spi_addr;
                ram_din   <= spi_wdata;
            end else if (grant_host) begin
                last_host <= 1'b1;
                gnt_spi   <= 1'b0;
                acc_we    <= host_we;
                ram_we    <= host_we;
                ram_addr  <= host_addr;
                ram_din   <= host_wdata;
            end
        end
    end

    // Read return; a read completing on the same edge as a new command still raises tx_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= 1'b0;
            if (accept) tx_valid <= 1'b0;
            if (state == RETURN) begin
                if (gnt_spi) begin
                    tx_data  <= ram_dout;
                    tx_valid <= 1'b1;
                end else begin
                    host_rdata  <= ram_dout;
                    host_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed scenarios and random SPI/host traffic, checked each
// cycle against a transaction-timing model; SPI_RD_ADDR_INC_EN adds the read-streaming case.
module tb_spi_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_din, ram_dout;
    logic       spi_ovf;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .spi_ovf(spi_ovf)
    );

    // RAM environment with a backdoor loader
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;
    logic [7:0] ram [256];
    logic [7:0] ram_q;
    int         ram_writes = 0;
    assign ram_dout = ram_q;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_en) begin
            if (ram_we) begin
                ram[ram_addr] <= ram_din;
                ram_writes    <= ram_writes + 1;
            end else begin
                ram_q <= ram[ram_addr];
            end
        end
    end

    // Reference model: arbiter availability tracked as "free from edge N"
    logic [7:0] ref_mem [256];
    int         cyc, m_free, m_spi_free, m_ret_at, m_inc_at, m_wr_at;
    logic       m_prev_rx, m_pend, m_pwe, m_last_host, m_ret_spi;
    logic [7:0] m_wr_addr, m_rd_addr, m_paddr, m_pdata, m_ret_data, m_wr_a, m_wr_d;
    logic       m_acc, m_busy, g_spi, g_host, g_we;
    logic [7:0] g_a, g_d;
    logic       e_en, e_we, e_gnt, e_rvalid, e_txv, e_ovf;
    logic [7:0] e_addr, e_din, e_rdata, e_txd;

    always @(posedge clk or negedge rst_n) begin
        if (bd_we) ref_mem[bd_addr] = bd_data;
        if (!rst_n) begin
            cyc = 0; m_free = 0; m_spi_free = 0; m_ret_at = -1; m_inc_at = -1; m_wr_at = -1;
            m_prev_rx = 0; m_pend = 0; m_pwe = 0; m_last_host = 1; m_ret_spi = 0;
            m_wr_addr = 0; m_rd_addr = 0; m_paddr = 0; m_pdata = 0; m_ret_data = 0;
            m_wr_a = 0; m_wr_d = 0;
            e_en = 0; e_we = 0; e_gnt = 0; e_rvalid = 0; e_txv = 0; e_ovf = 0;
            e_addr = 0; e_din = 0; e_rdata = 0; e_txd = 0;
        end else begin
            cyc++;
            m_acc     = rx_valid && !m_prev_rx;
            m_prev_rx = rx_valid;
            m_busy    = m_pend || (cyc < m_spi_free);
            e_en = 0; e_we = 0; e_gnt = 0; e_rvalid = 0;
            if (cyc == m_wr_at) ref_mem[m_wr_a] = m_wr_d;
            if (cyc == m_inc_at) m_rd_addr++;
            g_spi = 0; g_host = 0;
            if (cyc >= m_free) begin
                if (m_pend && (!host_req || m_last_host)) g_spi = 1;
                else if (host_req) g_host = 1;
            end
            if (g_spi || g_host) begin
                if (g_spi) begin g_we = m_pwe; g_a = m_paddr; g_d = m_pdata; m_pend = 0; end
                else begin g_we = host_we; g_a = host_addr; g_d = host_wdata; end
                m_last_host = g_host;
                e_en = 1; e_we = g_we; e_addr = g_a; e_din = g_d; e_gnt = g_host;
                m_free = cyc + (g_we ? 2 : 3);
                if (g_spi) m_spi_free = m_free;
                if (g_we) begin
                    m_wr_at = cyc + 1; m_wr_a = g_a; m_wr_d = g_d;
                end else begin
                    m_ret_at = cyc + 2; m_ret_spi = g_spi; m_ret_data = ref_mem[g_a];
`ifdef SPI_RD_ADDR_INC_EN
                    if (g_spi) m_inc_at = cyc + 1;
`endif
                end
            end
            if (m_acc) begin
                e_txv = 0;
                case (rx_data[9:8])
                    2'b00: m_wr_addr = rx_data[7:0];
                    2'b10: m_rd_addr = rx_data[7:0];
                    default: begin
                        if (m_busy) e_ovf = 1;
                        else begin
                            m_pend  = 1;
                            m_pwe   = !rx_data[9];
                            m_paddr = rx_data[9] ? m_rd_addr : m_wr_addr;
                            m_pdata = rx_data[7:0];
                        end
                    end
                endcase
            end
            if (cyc == m_ret_at) begin
                if (m_ret_spi) begin e_txv = 1; e_txd = m_ret_data; end
                else begin e_rvalid = 1; e_rdata = m_ret_data; end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk1("ram_en", ram_en, e_en);
        chk1("ram_we", ram_we, e_we);
        if (e_en) chk8("ram_addr", ram_addr, e_addr);
        if (e_en && e_we) chk8("ram_din", ram_din, e_din);
        chk1("host_gnt", host_gnt, e_gnt);
        chk1("host_rvalid", host_rvalid, e_rvalid);
        if (e_rvalid) chk8("host_rdata", host_rdata, e_rdata);
        chk1("tx_valid", tx_valid, e_txv);
        if (e_txv) chk8("tx_data", tx_data, e_txd);
        chk1("spi_ovf", spi_ovf, e_ovf);
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) compare_all();
        if (host_gnt) host_req = 1'b0;
    endtask

    task automatic spi_send(input logic [9:0] w, input int hold);
        rx_data = w; rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic host_issue(input logic we, input logic [7:0] a, input logic [7:0] d);
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_ram_en"}, ram_en, 1'b0);
        chk1({tag, "_ram_we"}, ram_we, 1'b0);
        chk8({tag, "_ram_addr"}, ram_addr, 8'h00);
        chk8({tag, "_ram_din"}, ram_din, 8'h00);
        chk1({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk8({tag, "_tx_data"}, tx_data, 8'h00);
        chk1({tag, "_host_gnt"}, host_gnt, 1'b0);
        chk1({tag, "_host_rvalid"}, host_rvalid, 1'b0);
        chk8({tag, "_host_rdata"}, host_rdata, 8'h00);
        chk1({tag, "_spi_ovf"}, spi_ovf, 1'b0);
    endtask

    int   w0, hold;
    logic found;

    initial begin
        rx_data = '0; rx_valid = 1'b0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        for (int i = 0; i < 256; i++) begin
            bd_we = 1'b1; bd_addr = 8'(i); bd_data = 8'($urandom);
            tick();
        end
        bd_we = 1'b0;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // SPI write 0xA5 to address 5, then read it back
        spi_send(10'h005, 1);
        spi_send(10'h1A5, 1);
        spi_send(10'h205, 1);
        rx_data = 10'h300; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        chk1("rd_tx_valid_e2", tx_valid, 1'b0);
        tick();
        chk1("rd_tx_valid_e3", tx_valid, 1'b1);
        chk8("rd_tx_data", tx_data, 8'hA5);
        repeat (3) tick();
        chk1("rd_tx_valid_held", tx_valid, 1'b1);
        chk8("ram5_after_write", ram[5], 8'hA5);
        rx_data = 10'h005; rx_valid = 1'b1;
        tick();
        chk1("tx_valid_cleared", tx_valid, 1'b0);
        rx_valid = 1'b0;
        tick();

        // Level held 8 cycles gives one write
        w0 = ram_writes;
        spi_send(10'h1C3, 8);
        repeat (3) tick();
        chk8("held_level_writes", 8'(ram_writes - w0), 8'd1);
        chk8("ram5_after_held", ram[5], 8'hC3);

        // Host read of 0x10 holding 0x77
        bd_we = 1'b1; bd_addr = 8'h10; bd_data = 8'h77;
        tick();
        bd_we = 1'b0;
        host_issue(1'b0, 8'h10, 8'h00);
        tick();
        chk1("host_gnt_latency", host_gnt, 1'b1);
        tick();
        chk1("host_rvalid_early", host_rvalid, 1'b0);
        tick();
        chk1("host_rvalid_latency", host_rvalid, 1'b1);
        chk8("host_rdata_0x10", host_rdata, 8'h77);
        tick();

        // Tie after reset: SPI first, host at the next ARB cycle
        do_reset();
        rx_data = 10'h111; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        host_issue(1'b1, 8'h20, 8'h22);
        tick();
        chk1("tie1_spi_en", ram_en, 1'b1);
        chk1("tie1_spi_not_host", host_gnt, 1'b0);
        chk8("tie1_spi_addr", ram_addr, 8'h00);
        tick();
        chk1("tie1_gap", ram_en, 1'b0);
        tick();
        chk1("tie1_host_gnt", host_gnt, 1'b1);
        chk8("tie1_host_addr", ram_addr, 8'h20);
        tick();
        spi_send(10'h1AA, 1);
        tick();
        // Tie with SPI granted last: host wins
        rx_data = 10'h1BB; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        host_issue(1'b1, 8'h21, 8'h33);
        tick();
        chk1("tie2_host_gnt", host_gnt, 1'b1);
        chk8("tie2_host_addr", ram_addr, 8'h21);
        tick(); tick();
        chk1("tie2_spi_en", ram_en, 1'b1);
        chk8("tie2_spi_din", ram_din, 8'hBB);
        tick();

        // Second SPI write while the first is stalled behind a host read
        do_reset();
        w0 = ram_writes;
        host_issue(1'b0, 8'h40, 8'h00);
        rx_data = 10'h155; rx_valid = 1'b1;
        tick();
        chk1("ovf_host_first", host_gnt, 1'b1);
        rx_valid = 1'b0;
        tick();
        rx_data = 10'h166; rx_valid = 1'b1;
        tick();
        chk1("ovf_set", spi_ovf, 1'b1);
        rx_valid = 1'b0;
        repeat (4) tick();
        chk8("ovf_one_write", 8'(ram_writes - w0), 8'd1);
        chk8("ovf_ram0", ram[0], 8'h55);

        // Reset during ACCESS
        w0 = ram_writes;
        rx_data = 10'h177; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            if (ram_en) found = 1'b1;
        end
        chk1("rst_reach_access", found, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk8("midrst_no_write", 8'(ram_writes - w0), 8'd0);
        chk8("midrst_ram0", ram[0], 8'h55);

`ifdef SPI_RD_ADDR_INC_EN
        bd_we = 1'b1; bd_addr = 8'hFF; bd_data = 8'hAB;
        tick();
        bd_addr = 8'h00; bd_data = 8'hCD;
        tick();
        bd_we = 1'b0;
        spi_send(10'h2FF, 1);
        spi_send(10'h300, 1);
        repeat (3) tick();
        chk8("inc_rd_ff", tx_data, 8'hAB);
        spi_send(10'h300, 1);
        repeat (3) tick();
        chk8("inc_rd_wrap", tx_data, 8'hCD);
`endif

        // Random SPI and host traffic
        hold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (rx_valid) begin
                hold--;
                if (hold == 0) rx_valid = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                rx_data  = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
                rx_valid = 1'b1;
                hold     = $urandom_range(1, 4);
            end
            if (!host_req && $urandom_range(0, 2) == 0)
                host_issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            tick();
            if (n == 750) begin
                rx_valid = 1'b0;
                host_req = 1'b0;
                do_reset();
            end
        end
        rx_valid = 1'b0;
        host_req = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Controller between the SPI slave command stream and the single-port RAM. A second on-chip requester, the host port, shares the same RAM port. The block does the following:
- decodes the slave's 10-bit command words;
- holds the write and read address registers;
- arbitrates RAM access round-robin between SPI and host;
- returns read data to the slave on tx_data/tx_valid, and to the host on host_rdata/host_rvalid.

## Interface
- ADDR_SIZE, 8, RAM address width; the RAM data word is fixed at 8 bits.
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  10  SPI command word: [9:8] opcode, [7:0] payload
- rx_valid  in  1  from slave; level, may stay high for several cycles
- tx_data  out  8  read data to slave
- tx_valid  out  1  tx_data valid; held high until next accepted SPI command
- host_req  in  1  host access request; held until granted
- host_we  in  1  1 = write, 0 = read; sampled with host_req
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  8  host write data
- host_gnt  out  1  one-cycle pulse; the host access is on the RAM port this cycle
- host_rvalid  out  1  one-cycle pulse with host_rdata
- host_rdata  out  8  host read data
- ram_en, ram_we  out  1 each  RAM port enable and write strobe
- ram_addr  out  ADDR_SIZE  RAM address
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data, valid the cycle after a read access
- spi_ovf  out  1  sticky: an SPI RAM command was dropped because one was already pending

## Operation
**Command acceptance**
- An SPI command is accepted only on a rising edge of rx_valid (registered edge detect).
- A level that stays high is not re-accepted.
- Every accepted command clears tx_valid.

**Opcodes**
- 00: wr_addr <= payload. No RAM access.
- 10: rd_addr <= payload. No RAM access.
- 01: sets spi_pend, with spi_we=1, address wr_addr and data = payload.
- 11: sets spi_pend, with spi_we=0 and address rd_addr.
- An 01 or 11 accepted while spi_pend or an SPI access is in flight is dropped, and spi_ovf is set. spi_ovf clears only on reset.

**FSM states**
- ARB
  - neither requester pending: stay in ARB
  - one pending: grant it
  - both pending: grant the one that was not last_grant
  - on a grant: go to ACCESS, update last_grant, and clear spi_pend if SPI was granted
- ACCESS
  - ram_en=1; ram_we, ram_addr and ram_din come from the granted request; host_gnt=1 if the host was granted
  - write: go to ARB
  - read: go to RETURN
- RETURN: capture ram_dout.
  - SPI read: tx_data <= ram_dout, tx_valid <= 1.
  - host read: host_rdata <= ram_dout, host_rvalid pulses for one cycle.
  - Then go to ARB.

**Rules**
- ram_en is 0 in ARB and RETURN. The RAM sees at most one access per ACCESS cycle.
- The host must hold host_req, host_we, host_addr and host_wdata stable until the host_gnt cycle. host_req may drop the cycle after host_gnt.
- An opcode 00/10 accepted while an SPI access is pending or in flight does not affect that access: its address was latched when the command was accepted.
- The RAM port is ADDR_SIZE bits wide, so ADDR_SIZE=8 covers all 256 locations.

## Timing
**Reset values**
- FSM = ARB, last_grant = HOST (so SPI wins the first tie).
- spi_pend, spi_ovf, tx_valid, host_gnt, host_rvalid, ram_en and ram_we = 0.
- tx_data, host_rdata, ram_addr, ram_din, wr_addr and rd_addr = 0.

**Latency** (edge E0 = the posedge sampling the rx_valid rise)
- spi_pend is set after E0.
- The ARB grant at E1 puts ram_en high between E1 and E2.
- The RAM operates at E2.
- For a read, tx_valid rises after E3 and stays high.
- Host: a request sampled in ARB at edge E gives host_gnt between E and E+1, and host_rvalid between E+2 and E+3.

**Throughput and contention**
- One write per 2 cycles; one read per 3 cycles.
- A losing requester is granted at the next ARB cycle.

**Reset mid-operation**
- Asserting rst_n low clears all outputs immediately, asynchronously. ram_en drops without waiting for a clock edge.
- Any pending or in-flight access is discarded.

## Configuration
Macro: SPI_RD_ADDR_INC_EN.
- Defined: each granted SPI read (opcode 11) increments rd_addr, modulo 2^ADDR_SIZE, at the ACCESS cycle. Consecutive 11 commands therefore stream sequential addresses, and 0xFF wraps to 0x00.
- Undefined: rd_addr changes only on opcode 10.

## Test plan
- SPI write/read:
  - send 0x005, then 0x1A5, then 0x205, then 0x300
  - -> RAM[5]=0xA5
  - -> tx_data=0xA5, with tx_valid high 3 cycles after the 0x300 edge, held until the next command
- rx_valid held high for 8 cycles with 0x1C3 -> exactly one RAM write.
- Host read of addr 0x10 holding 0x77 -> host_gnt 1 cycle after host_req, host_rvalid with 0x77 2 cycles after host_gnt.
- Simultaneous SPI write and host write in the same ARB cycle after reset -> SPI granted first; host granted at the next ARB cycle. Repeat the tie -> host granted first.
- Second 01 command arriving while host traffic stalls the first -> the second is dropped, spi_ovf=1, and only the first is written.
- rst_n asserted during ACCESS -> ram_en=0 and all outputs at reset values before the next clock edge. With SPI_RD_ADDR_INC_EN defined, 0x2FF followed by two 0x300 commands -> reads RAM[0xFF], then RAM[0x00].
